// File: rtl/gfx_pkg.sv
// Shared definitions for the graphics ROM arbiter: requester tags and arbiter states.
package gfx_pkg;
    localparam logic TAG_CHAR = 1'b0;
    localparam logic TAG_SPR  = 1'b1;

    typedef enum logic {IDLE, ISSUE} arb_state_e;
endpackage

// File: rtl/tag_fifo.sv
// DEPTH x 1-bit owner-tag FIFO; push and pop may happen in the same cycle.
module tag_fifo #(
    parameter int DEPTH = 4,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_din,
    input  logic          i_pop,
    output logic          o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);
    logic [DEPTH-1:0] r_mem;
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wp] <= i_din;
                r_wp        <= r_wp + 1'b1;
            end
            if (i_pop)
                r_rp <= r_rp + 1'b1;
            // Simultaneous push and pop leaves occupancy unchanged.
            if (i_push && !i_pop)
                r_cnt <= r_cnt + 1'b1;
            else if (i_pop && !i_push)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_dout  = r_mem[r_rp];
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
endmodule

// File: rtl/gfx_rom_arbiter.sv
// Shares one pipelined ROM read port between char and sprite fetch; char has
// priority, sprite is guaranteed a grant after STARVE_MAX blocked accepts.
module gfx_rom_arbiter
    import gfx_pkg::*;
#(
    parameter int AW         = 13,
    parameter int DW         = 16,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ch_req,
    input  logic [AW-1:0] ch_addr,
    output logic          ch_ack,
    output logic          ch_valid,
    output logic [DW-1:0] ch_data,
    input  logic          sp_req,
    input  logic [AW-1:0] sp_addr,
    output logic          sp_ack,
    output logic          sp_valid,
    output logic [DW-1:0] sp_data,
    output logic          rom_req,
    output logic [AW-1:0] rom_addr,
    input  logic          rom_rdy,
    input  logic          rom_dvalid,
    input  logic [DW-1:0] rom_data,
    output logic          busy,
    output logic          proto_err
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_e    r_state, w_state_nxt;
    logic [AW-1:0] r_rom_addr;
    logic          r_tag;
    logic [SW-1:0] r_starve;
    logic          r_ch_valid, r_sp_valid, r_proto_err;
    logic [DW-1:0] r_ch_data, r_sp_data;

    logic          w_fifo_head, w_fifo_full, w_fifo_empty;
    logic [CW-1:0] w_fifo_cnt;
    logic          w_push, w_pop, w_room, w_spr_win, w_ch_ack, w_sp_ack;

    assign w_pop  = rom_dvalid && !w_fifo_empty;
    assign w_push = (r_state == ISSUE) && rom_rdy;
    // A return in this cycle frees a slot for this cycle's accept.
    assign w_room = !w_fifo_full || w_pop;
    assign w_spr_win = sp_req && (!ch_req || r_starve == SW'(STARVE_MAX));

    tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
        .i_clk   (clk_sys),
        .i_rst_n (reset_n),
        .i_push  (w_push),
        .i_din   (r_tag),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_cnt)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ch_ack    = 1'b0;
        w_sp_ack    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_room) begin
                    w_sp_ack = w_spr_win;
                    w_ch_ack = ch_req && !w_spr_win;
                end
                if (w_ch_ack || w_sp_ack) w_state_nxt = ISSUE;
            end
            ISSUE: if (rom_rdy) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_addr  <= '0;
            r_tag       <= TAG_CHAR;
            r_starve    <= '0;
            r_ch_valid  <= 1'b0;
            r_sp_valid  <= 1'b0;
            r_ch_data   <= '0;
            r_sp_data   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_ch_ack || w_sp_ack) begin
                r_rom_addr <= w_sp_ack ? sp_addr : ch_addr;
                r_tag      <= w_sp_ack ? TAG_SPR : TAG_CHAR;
            end
            if (!sp_req || w_sp_ack)
                r_starve <= '0;
            else if (w_ch_ack)
                r_starve <= r_starve + 1'b1;

            r_ch_valid <= w_pop && (w_fifo_head == TAG_CHAR);
            r_sp_valid <= w_pop && (w_fifo_head == TAG_SPR);
            if (w_pop && w_fifo_head == TAG_CHAR) r_ch_data <= rom_data;
            if (w_pop && w_fifo_head == TAG_SPR)  r_sp_data <= rom_data;
            if (rom_dvalid && w_fifo_empty) r_proto_err <= 1'b1;
        end
    end

    assign ch_ack    = w_ch_ack;
    assign sp_ack    = w_sp_ack;
    assign rom_req   = (r_state == ISSUE);
    assign rom_addr  = r_rom_addr;
    assign ch_valid  = r_ch_valid;
    assign ch_data   = r_ch_data;
    assign sp_valid  = r_sp_valid;
    assign sp_data   = r_sp_data;
    assign busy      = (r_state == ISSUE) || (w_fifo_cnt != '0);
    assign proto_err = r_proto_err;
endmodule

// File: doc/gfx_rom_arbiter.md
Name: gfx_rom_arbiter

Overview:
- Shares one graphics ROM/SDRAM read port between two requesters: the tilemap character fetch and the sprite line-buffer fetch.
- Sits between the video block's char_rom_addr/spr_rom_addr fetch logic and the memory controller.
- Uses valid/ready request handshakes, a pipelined ROM port with in-order returns, and a tag FIFO to route returned data to its owner.
- Char fetch has fixed priority, with bounded sprite starvation.

Parameters:
- AW, 13, ROM word address width.
- DW, 16, ROM data width (two bitplanes, 8+8).
- DEPTH, 4, maximum outstanding ROM reads; power of two, 2..16.
- STARVE_MAX, 3, consecutive blocked cycles after which sprite wins one grant.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ch_req  in  1  char request valid
- ch_addr  in  AW  char ROM address; stable while ch_req && !ch_ack
- ch_ack  out  1  char request accepted (combinational ready)
- ch_valid  out  1  char read data valid, 1-cycle pulse
- ch_data  out  DW  char read data
- sp_req  in  1  sprite request valid
- sp_addr  in  AW  sprite ROM address
- sp_ack  out  1  sprite request accepted
- sp_valid  out  1  sprite read data valid pulse
- sp_data  out  DW  sprite read data
- rom_req  out  1  ROM read request
- rom_addr  out  AW  ROM read address
- rom_rdy  in  1  ROM accepts request this cycle
- rom_dvalid  in  1  ROM return data valid (in issue order)
- rom_data  in  DW  ROM return data
- busy  out  1  FIFO non-empty or request pending
- proto_err  out  1  sticky: return seen with no outstanding read

Behaviour:
- Reset (async assert, sync release):
  - rom_req=0, rom_addr=0, ch_valid=sp_valid=0, ch_data=sp_data=0, proto_err=0.
  - Tag FIFO empty, starve counter 0, state IDLE.
  - In-flight tags are discarded; the memory controller must be reset together with this block.
- State machine:
  - IDLE: if FIFO not full and any req is present, choose the winner. The winner's ack is high combinationally this cycle. On that edge, latch the address into rom_addr, latch the owner tag, set rom_req=1, and go to ISSUE.
  - ISSUE: hold rom_req and rom_addr. When rom_req && rom_rdy, push the tag (0=char, 1=sprite), drop rom_req, and return to IDLE.
  - Acceptance rate is at most one request per 2 cycles. The ROM sees a stable request until it is accepted.
- Acks:
  - ch_ack and sp_ack are 0 outside IDLE, 0 when the FIFO is full, and mutually exclusive.
  - A requester may present its next request in the cycle after its ack.
- Arbitration:
  - Char wins by default.
  - The starve counter increments each IDLE-accept cycle in which sp_req=1 and char wins. It clears on a sprite grant or when sp_req=0.
  - When counter == STARVE_MAX, the sprite wins even if ch_req=1, and the counter clears.
- Returns:
  - On rom_dvalid, pop the FIFO head tag.
  - Next cycle, the matching *_valid=1 and *_data=rom_data (1-cycle latency). The other *_data holds its old value.
- FIFO occupancy:
  - Counts pushes (ROM accept) minus pops (rom_dvalid). A simultaneous push and pop leaves the count unchanged.
  - "Full" uses the count including a pop in the same cycle: a pop frees a slot for that cycle's accept.
- Errors: rom_dvalid with an empty FIFO sets proto_err and produces no *_valid. It is cleared only by reset.
- Widths: occupancy counter is $clog2(DEPTH)+1 bits; read/write pointers wrap modulo DEPTH.
- busy = (state==ISSUE) || occupancy != 0.
- ROM acceptance while rom_dvalid returns the final entry: the push and pop are handled in the same cycle; ordering is preserved.

Decomposition:
- Shared package gfx_pkg: TAG_CHAR=1'b0, TAG_SPR=1'b1, and the arbiter state enum {IDLE, ISSUE}.
- One sub-module, tag_fifo: DEPTH x 1-bit, with push/pop/full/empty/count and simultaneous push+pop support.
- Arbitration and the state machine stay in the top module.

Test Plan:
- Single char read: ch_req with ch_addr=13'h0123, rom_rdy=1, return 16'hA55A 3 cycles later -> ch_ack for 1 cycle, rom_addr=0x0123, then ch_valid=1 and ch_data=A55A one cycle after rom_dvalid; sp_valid stays 0.
- Starvation bound: ch_req and sp_req both held continuously, STARVE_MAX=3 -> grant sequence C,C,C,S,C,C,C,S...; no sprite waits more than 3 char grants.
- FIFO full: DEPTH=4, rom_rdy=1, no returns -> 4 accepts, then ch_ack=sp_ack=0 and busy=1. One rom_dvalid -> exactly one more accept.
- Interleaved return routing: issue C(0x10), S(0x20), C(0x30); return D1,D2,D3 -> ch_valid with D1, sp_valid with D2, ch_valid with D3, in that order.
- ROM back-pressure: rom_rdy=0 for 5 cycles during ISSUE -> rom_req and rom_addr stable, no new ack; both change only after the rom_rdy pulse.
- Error and reset: rom_dvalid with an empty FIFO sets proto_err=1 and produces no valid. reset_n pulse mid-transaction -> all outputs return to reset values asynchronously and proto_err=0.
